huffman_arbiter: RTL and testbench
==================================

# huffman_arbiter

Sequencing controller that shares a single `huffman` encoder core between two pixel-stream requesters. It grants the core to one requester per frame using round-robin arbitration, and pulses the core reset before each frame because the core's count and code registers are cleared only by its reset. It forwards the granted stream, tracks the core through count-valid and code-valid, and signals per-requester completion or timeout. It sits between the frame sources and the core; downstream samples the core's CNT*/HC*/M* outputs on the reported pulses.

## Interface
- `TIMEOUT`, 255: watchdog limit in cycles for the wait-for-first-pixel, wait-for-count and wait-for-code phases.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  2  per-requester frame request, level.
- `gnt`  out  2  one-hot grant, registered.
- `px_valid`  in  2  per-requester pixel valid.
- `px_data`  in  16  per-requester pixel, `[8i+7:8i]` for requester i.
- `core_reset`  out  1  reset to core.
- `core_gray_valid`  out  1  to core `gray_valid`.
- `core_gray_data`  out  8  to core `gray_data`.
- `core_cnt_valid`  in  1  from core `CNT_valid`.
- `core_code_valid`  in  1  from core `code_valid`.
- `cnt_rdy`  out  2  one-hot pulse: counts valid for the granted requester.
- `done`  out  2  one-hot pulse: codes valid for the granted requester.
- `err`  out  2  one-hot pulse: watchdog abort for the granted requester.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CLR, STREAM, WAIT_CNT, WAIT_CODE, ABORT, RELEASE.
- IDLE, any `req` high: pick a winner, register `gnt`, go to CLR.
  - Round-robin: the requester served last has the lower priority.
  - After reset, requester 0 has priority.
- CLR: drive `core_reset=1` for exactly 1 cycle, then go to STREAM.
- STREAM:
  - `core_gray_valid = px_valid[sel]` and `core_gray_data = px_data[sel]`.
  - Outside STREAM, `core_gray_valid=0` and `core_gray_data=0`.
  - Frame starts at the first `px_valid[sel]=1`.
  - Frame ends at the first `px_valid[sel]=0` after the start; then go to WAIT_CNT.
  - `req[sel]` low before the first pixel: cancel, go to RELEASE with no done/err.
  - `req` changes after the first pixel are ignored.
- WAIT_CNT: on `core_cnt_valid`, go to WAIT_CODE.
  - `cnt_rdy[sel] = core_cnt_valid` while in WAIT_CNT (combinational).
- WAIT_CODE: on `core_code_valid`, go to RELEASE.
  - `done[sel] = core_code_valid` while in WAIT_CODE (combinational).
- Watchdog:
  - 8+ bit counter, cleared on every state entry.
  - Counts in STREAM before the first pixel, in WAIT_CNT and in WAIT_CODE.
  - Reaching `TIMEOUT`: go to ABORT.
  - STREAM after the first pixel is not timed.
- ABORT: 1 cycle; `err[sel]=1`, `core_reset=1`, then go to RELEASE.
- RELEASE: 1 cycle; update the round-robin pointer to `sel` (cancel included), then go to IDLE.
- `gnt` is high from CLR through WAIT_CODE/ABORT inclusive, and low in RELEASE and IDLE.
- `core_reset = reset | (state==CLR) | (state==ABORT)`.
- The block does no arithmetic on data; frames longer than 255 pixels wrap in the core and are not flagged.

## Timing
- Reset values: `gnt=0`, `cnt_rdy=0`, `done=0`, `err=0`, `busy=0`, `core_gray_valid=0`, `core_gray_data=0`, `core_reset=1` (via reset).
- State after reset: IDLE, pointer=0.
- `req` sampled in cycle t: `gnt` high at t+1 (CLR), core reset at t+1, forwarding from t+2.
- Pixel path is combinational: 0-cycle latency from `px_*` to `core_gray_*` in STREAM.
- Last pixel followed by the valid drop at cycle d: state is WAIT_CNT at d+1, the core asserts `CNT_valid` at d+1, and `cnt_rdy` pulses at d+1.
- `done` pulses in the same cycle as `core_code_valid`; `gnt` drops 1 cycle later, with RELEASE in that cycle.
- Minimum gap between frames: IDLE→CLR costs 2 cycles after RELEASE.
- Both `req` high in IDLE: the winner follows the pointer; the loser is served next if still requesting.
- `reset` mid-frame: immediate return to IDLE, all outputs at their reset values; no done/err pulse.

## Structure
- `huffman_pkg` holds:
  - the `arb_state_t` enum;
  - `NREQ=2`;
  - `HUF_TIMEOUT_DEF=255`.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick from `req` and the pointer, producing a one-hot winner.
- FSM, watchdog and muxing live in the top.

## Test plan
- Single frame from requester 0, pixels 1,1,2,6 → `gnt=01`, `core_reset` 1 cycle, `cnt_rdy[0]` one cycle after the valid drop, `done[0]` pulse, then `gnt=00`.
- `req=11` from reset → requester 0 is served first, then requester 1 with no intervening request; the third grant goes to 0 if both are still requesting.
- Back-to-back frames from requester 1 → `core_reset` pulses before each frame; the second frame's counts reflect only the second frame.
- Requester 0 granted but no pixel for `TIMEOUT` cycles → `err[0]` pulse, `core_reset=1` in the same cycle, release, then requester 1 granted.
- `req[1]` dropped before its first pixel → grant released with no done/err; the pointer advances to favour requester 0.
- `reset` asserted during WAIT_CODE → next cycle all outputs are at reset values, and the core's `code_valid` is ignored.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and constants for the huffman core sequencing controller.
package huffman_pkg;
  localparam int NREQ            = 2;
  localparam int HUF_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    WAIT_CNT,
    WAIT_CODE,
    ABORT,
    RELEASE
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: prio names the requester that wins a tie.
module rr_arbiter2
  import huffman_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            prio,
  output logic [NREQ-1:0] win
);
  always_comb begin
    win = '0;
    if (prio) begin
      if (req[1])      win = 2'b10;
      else if (req[0]) win = 2'b01;
    end else begin
      if (req[0])      win = 2'b01;
      else if (req[1]) win = 2'b10;
    end
  end
endmodule

// File: rtl/huffman_arbiter.sv
// Shares one huffman encoder core between two pixel streams, one frame per grant,
// clearing the core through its reset before every frame and on watchdog abort.
module huffman_arbiter
  import huffman_pkg::*;
#(
  parameter int TIMEOUT = HUF_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ-1:0]   px_valid,
  input  logic [8*NREQ-1:0] px_data,
  output logic              core_reset,
  output logic              core_gray_valid,
  output logic [7:0]        core_gray_data,
  input  logic              core_cnt_valid,
  input  logic              core_code_valid,
  output logic [NREQ-1:0]   cnt_rdy,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy
);
  localparam int WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  arb_state_t      state, state_n;
  logic            sel, sel_n;
  logic            started, started_n;
  logic            prio;
  logic [WDW-1:0]  wd;
  logic [NREQ-1:0] win;
  logic [NREQ-1:0] sel_oh;
  logic            pv;
  logic [7:0]      lane;
  logic            wd_exp;

  rr_arbiter2 u_rr (
    .req  (req),
    .prio (prio),
    .win  (win)
  );

  assign sel_oh = sel ? 2'b10 : 2'b01;
  assign pv     = px_valid[sel];
  assign lane   = sel ? px_data[15:8] : px_data[7:0];
  // Firing one count early makes the abort land exactly TIMEOUT cycles after entry.
  assign wd_exp = (wd == WDW'(TIMEOUT - 1));

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    started_n = started;
    case (state)
      IDLE: if (|req) begin
        state_n = CLR;
        sel_n   = win[1];
      end
      CLR: begin
        state_n   = STREAM;
        started_n = 1'b0;
      end
      STREAM: begin
        if (!started) begin
          if (!req[sel])   state_n = RELEASE;
          else if (pv)     started_n = 1'b1;
          else if (wd_exp) state_n = ABORT;
        end else if (!pv) begin
          state_n = WAIT_CNT;
        end
      end
      WAIT_CNT: begin
        if (core_cnt_valid) state_n = WAIT_CODE;
        else if (wd_exp)    state_n = ABORT;
      end
      WAIT_CODE: begin
        if (core_code_valid) state_n = RELEASE;
        else if (wd_exp)     state_n = ABORT;
      end
      ABORT:   state_n = RELEASE;
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pulses are masked by reset so a frame killed mid-flight reports nothing.
  always_comb begin
    core_gray_valid = 1'b0;
    core_gray_data  = 8'h00;
    cnt_rdy         = '0;
    done            = '0;
    err             = '0;
    if (!reset) begin
      if (state == STREAM) begin
        core_gray_valid = pv;
        core_gray_data  = lane;
      end
      if (state == WAIT_CNT && core_cnt_valid)   cnt_rdy = sel_oh;
      if (state == WAIT_CODE && core_code_valid) done    = sel_oh;
      if (state == ABORT)                        err     = sel_oh;
    end
  end

  assign busy       = (state != IDLE);
  assign core_reset = reset | (state == CLR) | (state == ABORT);

  // prio holds the requester favoured on a tie: the one not served last.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 1'b0;
      started <= 1'b0;
      prio    <= 1'b0;
      wd      <= '0;
      gnt     <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      started <= started_n;
      wd      <= (state_n != state) ? '0 : wd + 1'b1;
      if (state_n inside {CLR, STREAM, WAIT_CNT, WAIT_CODE, ABORT})
        gnt <= sel_n ? 2'b10 : 2'b01;
      else
        gnt <= '0;
      if (state == RELEASE) prio <= ~sel;
    end
  end
endmodule

// File: tb/tb_huffman_arbiter.sv
// Frame-level randomized bench: the bench plays both requesters and the core,
// predicting winners and pulse cycles from the round-robin and watchdog rules.
module tb_huffman_arbiter;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  px_valid;
  logic [15:0] px_data;
  logic        core_reset;
  logic        core_gray_valid;
  logic [7:0]  core_gray_data;
  logic        core_cnt_valid;
  logic        core_code_valid;
  logic [1:0]  cnt_rdy;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        busy;

  int          n_chk = 0;
  int          n_fail = 0;
  logic        prio;
  logic [7:0]  dpx[$];

  always #5 clk = ~clk;

  huffman_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .gnt             (gnt),
    .px_valid        (px_valid),
    .px_data         (px_data),
    .core_reset      (core_reset),
    .core_gray_valid (core_gray_valid),
    .core_gray_data  (core_gray_data),
    .core_cnt_valid  (core_cnt_valid),
    .core_code_valid (core_code_valid),
    .cnt_rdy         (cnt_rdy),
    .done            (done),
    .err             (err),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane(input logic s);
    return s ? px_data[15:8] : px_data[7:0];
  endfunction

  task automatic rnd_io();
    px_valid = 2'($urandom);
    px_data  = 16'($urandom);
  endtask

  // Check every output in the current cycle, then advance to just after the next edge.
  task automatic cyc(input string t, input logic [1:0] eg, input logic eb, input logic ecr,
                     input logic egv, input logic [7:0] egd,
                     input logic [1:0] ec, input logic [1:0] ed, input logic [1:0] ee);
    #1;
    chk({t, ".gnt"}, 32'(gnt), 32'(eg));
    chk({t, ".busy"}, 32'(busy), 32'(eb));
    chk({t, ".core_reset"}, 32'(core_reset), 32'(ecr));
    chk({t, ".gray_valid"}, 32'(core_gray_valid), 32'(egv));
    chk({t, ".gray_data"}, 32'(core_gray_data), 32'(egd));
    chk({t, ".cnt_rdy"}, 32'(cnt_rdy), 32'(ec));
    chk({t, ".done"}, 32'(done), 32'(ed));
    chk({t, ".err"}, 32'(err), 32'(ee));
    @(posedge clk);
    #1;
  endtask

  task automatic rel_cyc(input logic si);
    rnd_io();
    cyc("release", 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
    prio = ~si;
  endtask

  task automatic abort_rel(input logic [1:0] w, input logic si);
    rnd_io();
    cyc("abort", w, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, w);
    rel_cyc(si);
  endtask

  // scn: 0 normal, 1 cancel, 2 no-pixel timeout, 3 count timeout,
  //      4 code timeout, 5 reset during code wait
  task automatic frame(input logic [1:0] pat, input int scn);
    logic       si;
    logic [1:0] w;
    int         k, n, l;
    bit         fixed;
    fixed = (dpx.size() != 0);
    si = (pat == 2'b11) ? prio : pat[1];
    w  = si ? 2'b10 : 2'b01;

    req = pat;
    core_cnt_valid  = 1'($urandom);
    core_code_valid = 1'($urandom);
    rnd_io();
    cyc("idle", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
    rnd_io();
    cyc("clr", w, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
    core_cnt_valid  = 1'b0;
    core_code_valid = 1'b0;

    k = fixed ? 0 : $urandom_range(0, 4);
    if (scn == 2) k = TIMEOUT;
    for (int i = 0; i < k; i++) begin
      rnd_io();
      px_valid[si] = 1'b0;
      cyc("wait_px", w, 1'b1, 1'b0, 1'b0, lane(si), 2'b00, 2'b00, 2'b00);
    end
    if (scn == 2) begin abort_rel(w, si); return; end
    if (scn == 1) begin
      rnd_io();
      px_valid[si] = 1'b0;
      req[si] = 1'b0;
      cyc("cancel", w, 1'b1, 1'b0, 1'b0, lane(si), 2'b00, 2'b00, 2'b00);
      rel_cyc(si);
      return;
    end

    n = fixed ? dpx.size() : $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      rnd_io();
      px_valid[si] = 1'b1;
      if (fixed) px_data[int'(si)*8 +: 8] = dpx[i];
      if (i > 0) req[si] = 1'($urandom);
      cyc("pixel", w, 1'b1, 1'b0, 1'b1, lane(si), 2'b00, 2'b00, 2'b00);
    end
    dpx.delete();
    rnd_io();
    px_valid[si] = 1'b0;
    cyc("drop", w, 1'b1, 1'b0, 1'b0, lane(si), 2'b00, 2'b00, 2'b00);

    l = (scn == 3) ? TIMEOUT : (fixed ? 0 : $urandom_range(0, 3));
    for (int i = 0; i < l; i++) begin
      rnd_io();
      core_code_valid = 1'($urandom);
      cyc("wait_cnt", w, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
    end
    core_code_valid = 1'b0;
    if (scn == 3) begin abort_rel(w, si); return; end
    rnd_io();
    core_cnt_valid = 1'b1;
    cyc("cnt_rdy", w, 1'b1, 1'b0, 1'b0, 8'h00, w, 2'b00, 2'b00);

    l = (scn == 4) ? TIMEOUT : (fixed ? 0 : $urandom_range(0, 3));
    for (int i = 0; i < l; i++) begin
      rnd_io();
      core_cnt_valid = 1'($urandom);
      cyc("wait_code", w, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
    end
    core_cnt_valid = 1'b0;
    if (scn == 4) begin abort_rel(w, si); return; end
    if (scn == 5) begin
      rnd_io();
      reset = 1'b1;
      core_code_valid = 1'b1;
      cyc("rst_code", w, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
      reset = 1'b0;
      req = 2'b00;
      rnd_io();
      cyc("post_rst", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
      core_code_valid = 1'b0;
      prio = 1'b0;
      return;
    end
    rnd_io();
    core_code_valid = 1'b1;
    cyc("done", w, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, w, 2'b00);
    core_code_valid = 1'b0;
    rel_cyc(si);
  endtask

  initial begin
    int r, scn;
    reset = 1'b1;
    req = 2'b00;
    px_valid = 2'b00;
    px_data = 16'h0;
    core_cnt_valid = 1'b0;
    core_code_valid = 1'b0;
    prio = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      req = 2'($urandom);
      core_cnt_valid = 1'($urandom);
      core_code_valid = 1'($urandom);
      rnd_io();
      cyc("reset", 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
    end
    reset = 1'b0;
    core_cnt_valid = 1'b0;
    core_code_valid = 1'b0;

    // both requesting from reset: 0, 1, 0
    frame(2'b11, 0);
    frame(2'b11, 0);
    frame(2'b11, 0);
    // single frame from requester 0 with a known pixel sequence
    dpx = '{8'd1, 8'd1, 8'd2, 8'd6};
    frame(2'b01, 0);
    // back-to-back frames from requester 1
    frame(2'b10, 0);
    frame(2'b10, 0);
    // requester 0 starved of pixels, then requester 1 gets the core
    frame(2'b11, 2);
    frame(2'b11, 0);
    // requester 1 cancels; a tie afterwards goes to requester 0
    frame(2'b10, 1);
    frame(2'b11, 0);
    // watchdogs in the core wait phases, then reset during the code wait
    frame(2'b01, 3);
    frame(2'b10, 4);
    frame(2'b11, 5);
    frame(2'b11, 0);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 2'b00;
        rnd_io();
        cyc("idle_noreq", 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00);
      end
      r = $urandom_range(0, 15);
      scn = (r < 9) ? 0 : (r < 11) ? 1 : (r == 11) ? 2 : (r == 12) ? 3 : (r == 13) ? 4 : 5;
      frame(2'($urandom_range(1, 3)), scn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
